// File: rtl/bcd_counter_ndigit_pkg.sv
// Shared constants and helpers for the multi-digit BCD counter.
package bcd_counter_ndigit_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_ZERO = 4'd0;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_STEP = 2'd1,
    OP_LOAD = 2'd2,
    OP_CLR  = 2'd3
  } op_e;

  function automatic logic bcd_valid(input logic [DIGIT_W-1:0] nib);
    return nib <= BCD_MAX;
  endfunction

  // Clear beats load beats step; anything lower in the same cycle is dropped.
  function automatic op_e op_decode(input logic clr, input logic load, input logic step);
    if (clr)       return OP_CLR;
    else if (load) return OP_LOAD;
    else if (step) return OP_STEP;
    else           return OP_HOLD;
  endfunction

endpackage

// File: rtl/bcd_counter_ndigit_digit.sv
// Single BCD digit register: sync clear/load, up/down step with 9<->0 rollover.
module bcd_digit
  import bcd_counter_ndigit_pkg::*;
(
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic               in_clr,
  input  logic               in_load,
  input  logic [DIGIT_W-1:0] in_load_val,
  input  logic               in_step,
  input  logic               in_up,
  output logic [DIGIT_W-1:0] o_d,
  output logic               o_is9,
  output logic               o_is0
);

  logic [DIGIT_W-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    case (op_decode(in_clr, in_load, in_step))
      OP_CLR:  digit_d = BCD_ZERO;
      OP_LOAD: digit_d = bcd_valid(in_load_val) ? in_load_val : BCD_ZERO;
      OP_STEP: begin
        if (in_up) digit_d = (digit_q == BCD_MAX)  ? BCD_ZERO : digit_q + 4'd1;
        else       digit_d = (digit_q == BCD_ZERO) ? BCD_MAX  : digit_q - 4'd1;
      end
      default: digit_d = digit_q;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) digit_q <= BCD_ZERO;
    else        digit_q <= digit_d;
  end

  assign o_d   = digit_q;
  assign o_is9 = (digit_q == BCD_MAX);
  assign o_is0 = (digit_q == BCD_ZERO);

endmodule

// File: rtl/bcd_counter_ndigit.sv
// N-digit packed-BCD up/down counter with cascade carry, wrap and load-error pulses.
module bcd_counter_ndigit
  import bcd_counter_ndigit_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_en,
  input  logic                    in_up,
  input  logic                    in_clr,
  input  logic                    in_load,
  input  logic [4*DIGITS-1:0]     in_load_val,
  output logic [4*DIGITS-1:0]     o_q,
  output logic                    o_tc,
  output logic                    o_wrap,
  output logic                    o_load_err
);

  logic [DIGITS:0]   chain;
  logic [DIGITS-1:0] is9, is0, nib_bad;
  logic              wrap_q, wrap_d;
  logic              load_err_q, load_err_d;
  op_e               op;

  // chain[k] is high when every digit below k sits at the rollover value.
  assign chain[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign chain[k+1] = chain[k] & (in_up ? is9[k] : is0[k]);
    assign nib_bad[k] = ~bcd_valid(in_load_val[k*DIGIT_W +: DIGIT_W]);

    bcd_digit u_digit (
      .in_clk      (in_clk),
      .in_rst      (in_rst),
      .in_clr      (in_clr),
      .in_load     (in_load),
      .in_load_val (in_load_val[k*DIGIT_W +: DIGIT_W]),
      .in_step     (in_en & chain[k]),
      .in_up       (in_up),
      .o_d         (o_q[k*DIGIT_W +: DIGIT_W]),
      .o_is9       (is9[k]),
      .o_is0       (is0[k])
    );
  end

  assign op   = op_decode(in_clr, in_load, in_en);
  assign o_tc = (op == OP_STEP) & chain[DIGITS];

  always_comb begin
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    case (op)
      OP_STEP: wrap_d     = chain[DIGITS];
      OP_LOAD: load_err_d = |nib_bad;
      default: ;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign o_wrap     = wrap_q;
  assign o_load_err = load_err_q;

endmodule

// File: doc/bcd_counter_ndigit.md
Name: bcd_counter_ndigit

Overview:
Parametrised multi-digit BCD up/down counter, the successor to the team's single-digit 4-bit BCD counter. Adds a configurable digit count, count enable, direction select, synchronous clear, and parallel load with per-digit validity checking. It also provides a combinational cascade carry/borrow for chaining instances, plus a registered wrap pulse. Used for decimal event counting and display front-ends (7-seg drivers downstream).

Parameters:
DIGITS, 4, number of BCD digits (1..8); output width 4*DIGITS.

Ports:
in_clk  input  1  clock, rising edge.
in_rst  input  1  reset, asynchronous, active-high.
in_en  input  1  count enable; one step per clock when high.
in_up  input  1  direction: 1 = increment, 0 = decrement.
in_clr  input  1  synchronous clear to all zeros.
in_load  input  1  synchronous parallel load.
in_load_val  input  4*DIGITS  load value; digit k is bits [4k+3:4k], digit 0 is least significant.
o_q  output  4*DIGITS  current count, packed BCD.
o_tc  output  1  combinational terminal count / cascade carry.
o_wrap  output  1  registered one-cycle pulse after a wrap.
o_load_err  output  1  registered one-cycle pulse after a load that contained an invalid digit.

Behaviour:
- Reset (async, in_rst=1): o_q=0, o_wrap=0, o_load_err=0. Held while in_rst is high. Release takes effect at the next rising edge.
- Priority per edge: in_clr > in_load > in_en. Lower-priority requests in the same cycle are ignored.
- in_clr: o_q<=0. o_wrap<=0 and o_load_err<=0 on that edge.
- in_load: each digit k loads in_load_val nibble k if that nibble is <=9; otherwise the digit loads 0.
  - o_load_err<=1 for one cycle if any nibble was >9, else 0.
  - o_wrap<=0.
- Counting when in_en=1 and no clr/load:
  - Up: digit 0 steps +1. Digit k steps only when all lower digits are 9. A digit at 9 that steps goes to 0.
  - Down: digit 0 steps -1. Digit k steps only when all lower digits are 0. A digit at 0 that steps goes to 9.
- Wrap: up from all-9s gives all-0s; down from all-0s gives all-9s. On the wrapping edge o_wrap<=1; on every other edge o_wrap<=0.
- in_en=0 and no clr/load: o_q holds; o_wrap and o_load_err return to 0.
- o_tc (combinational, no register) = in_en & ~in_clr & ~in_load & (in_up ? all digits==9 : all digits==0). Wire it to the next instance's in_en for cascading.
- Latency: o_q updates on the same edge as the request. o_wrap and o_load_err are valid the cycle after the triggering edge, each exactly one cycle wide.
- Direction change takes effect immediately on the next enabled edge; there is no pipeline state.
- Digits never hold values >9 after reset, clear, load, or count. Verification asserts this invariant every cycle.

Decomposition:
- Shared package: BCD_MAX=4'd9, BCD_ZERO=4'd0, DIGIT_W=4. Also a function for the digit-is-valid (<=9) check.
- Sub-module bcd_digit: one 4-bit digit register with async reset, sync clear/load, up/down step on in_step. Outputs o_is9 and o_is0.
- The top level generates DIGITS instances of bcd_digit and builds the ripple-enable chain as an AND-prefix of o_is9 or o_is0 selected by in_up. It also holds the o_wrap and o_load_err flops.

Test Plan:
1. Reset mid-count: count to 0x0123, assert in_rst asynchronously between edges. o_q=0x0000 immediately; o_wrap=0 and o_load_err=0.
2. Up carry: load 0x0199, en=1, up=1, one edge. o_q=0x0200, o_wrap=0, o_tc=0 throughout.
3. Up wrap: load 0x9999, en=1, up=1. o_tc=1 before the edge; after the edge o_q=0x0000; next cycle o_wrap=1 for exactly one cycle.
4. Down borrow/wrap: load 0x1000, up=0, one edge gives 0x0999. Then load 0x0000, one edge gives 0x9999 with an o_wrap pulse.
5. Invalid load: in_load_val=0x3A7F. o_q=0x3070; o_load_err pulses one cycle. Load 0x3479 gives o_load_err=0.
6. Priority/cascade: in_clr=1, in_load=1, in_en=1 together gives o_q=0x0000. Two DIGITS=2 instances chained via o_tc count 0..9999 in sequence, with every digit <=9 on every cycle.
